// File: rtl/lat_line_mem.sv
// -----------------------------------------------------------------------------
// lat_line_mem
//
// Fixed-latency, line-wide memory model with NUM_PORTS independent channels
// sharing one word array. Each channel accepts one request when idle, holds it
// for LATENCY cycles and then performs the read or masked write, pulsing
// resp_valid for one cycle.
//
// Handshake (valid/ready): a request is accepted on a rising edge where both
// req_valid[p] and ready[p] are high. While ready[p] is low, req_valid[p] and
// all request fields are ignored (never queued). resp_valid[p] is a one-cycle
// pulse that coincides with ready[p] returning high.
//
// Parameters:
//   WORD_SIZE  - bits per word
//   ADDR_WIDTH - word address bits, DEPTH = 2**ADDR_WIDTH
//   LINE_WORDS - words per transfer (power of two, 1..DEPTH)
//   LATENCY    - cycles from accept to completion (>= 1)
//   NUM_PORTS  - number of channels (>= 1)
//
// Ports (port p occupies slice p of every packed bus):
//   clk, reset  - posedge clock, synchronous active-high reset
//   req_valid   - request strobe
//   req_write   - 1 = write, 0 = read
//   req_addr    - word address (low line-offset bits ignored)
//   req_wdata   - write line, word k at slice k of the port's line
//   req_wmask   - per-word write enable
//   ready       - channel idle
//   resp_valid  - completion pulse (reads and writes)
//   resp_rdata  - last read line, word 0 = lowest address
//   resp_addr   - line-aligned address of the completed op
//
// Optional build macro LAT_LINE_MEM_STATS_EN adds stat_reads / stat_writes:
// per-port saturating 16-bit completion counters, cleared by reset.
// -----------------------------------------------------------------------------
module lat_line_mem #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4,
    parameter int NUM_PORTS  = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    input  logic [NUM_PORTS-1:0]                   req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_PORTS*LINE_WORDS*WORD_SIZE-1:0] req_wdata,
    input  logic [NUM_PORTS*LINE_WORDS-1:0]        req_wmask,
    output logic [NUM_PORTS-1:0]                   ready,
    output logic [NUM_PORTS-1:0]                   resp_valid,
    output logic [NUM_PORTS*LINE_WORDS*WORD_SIZE-1:0] resp_rdata,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0]        resp_addr
`ifdef LAT_LINE_MEM_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]                stat_reads,
    output logic [NUM_PORTS*16-1:0]                stat_writes
`endif
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int LINE_BITS = LINE_WORDS * WORD_SIZE;
    localparam int CNT_W     = $clog2(LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(1);

    logic [WORD_SIZE-1:0]  mem [DEPTH];

    // Per-port countdown: 0 = idle, LATENCY..1 = busy, 1 = completing this edge.
    logic [CNT_W-1:0]      cnt        [NUM_PORTS];
    logic                  hold_write [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] hold_line  [NUM_PORTS];
    logic [LINE_BITS-1:0]  hold_wdata [NUM_PORTS];
    logic [LINE_WORDS-1:0] hold_wmask [NUM_PORTS];

    logic [NUM_PORTS-1:0]  accept;
    logic [NUM_PORTS-1:0]  done;

    always_comb begin
        ready  = '0;
        accept = '0;
        done   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            ready[p]  = (cnt[p] == '0);
            accept[p] = ready[p] & req_valid[p];
            done[p]   = (cnt[p] == CNT_LAST);
        end
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (reset) begin
                cnt[p]        <= '0;
                resp_valid[p] <= 1'b0;
                resp_rdata[p*LINE_BITS +: LINE_BITS]  <= '0;
                resp_addr[p*ADDR_WIDTH +: ADDR_WIDTH] <= '0;
            end else begin
                resp_valid[p] <= 1'b0;
                if (accept[p]) begin
                    cnt[p] <= CNT_LOAD;
                end else if (done[p]) begin
                    cnt[p]        <= '0;
                    resp_valid[p] <= 1'b1;
                    resp_addr[p*ADDR_WIDTH +: ADDR_WIDTH] <= hold_line[p];
                    // Non-blocking read sees the array before any write
                    // completing on this same edge.
                    if (!hold_write[p]) begin
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            resp_rdata[p*LINE_BITS + k*WORD_SIZE +: WORD_SIZE]
                                <= mem[hold_line[p] + ADDR_WIDTH'(k)];
                        end
                    end
                end else if (cnt[p] != '0) begin
                    cnt[p] <= cnt[p] - 1'b1;
                end
            end
        end
    end

    // Request holding registers; pure data path, loaded only at accept.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p]) begin
                hold_write[p] <= req_write[p];
                hold_line[p]  <= req_addr[p*ADDR_WIDTH +: ADDR_WIDTH] & ~LINE_MASK;
                hold_wdata[p] <= req_wdata[p*LINE_BITS +: LINE_BITS];
                hold_wmask[p] <= req_wmask[p*LINE_WORDS +: LINE_WORDS];
            end
        end
    end

    // Array write. Ports are visited from highest to lowest index so that the
    // lowest-index port's assignment is the last one and wins on a collision.
    // Reset suppresses the write, aborting an op that would complete now.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (!reset && done[p] && hold_write[p]) begin
                for (int k = 0; k < LINE_WORDS; k++) begin
                    if (hold_wmask[p][k]) begin
                        mem[hold_line[p] + ADDR_WIDTH'(k)]
                            <= hold_wdata[p][k*WORD_SIZE +: WORD_SIZE];
                    end
                end
            end
        end
    end

`ifdef LAT_LINE_MEM_STATS_EN
    logic [15:0] rd_cnt [NUM_PORTS];
    logic [15:0] wr_cnt [NUM_PORTS];

    // Counted at completion, so aborted ops never reach these counters.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (reset) begin
                rd_cnt[p] <= '0;
                wr_cnt[p] <= '0;
            end else if (done[p]) begin
                if (hold_write[p]) begin
                    if (wr_cnt[p] != 16'hFFFF) wr_cnt[p] <= wr_cnt[p] + 16'd1;
                end else begin
                    if (rd_cnt[p] != 16'hFFFF) rd_cnt[p] <= rd_cnt[p] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_reads  = '0;
        stat_writes = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            stat_reads[p*16 +: 16]  = rd_cnt[p];
            stat_writes[p*16 +: 16] = wr_cnt[p];
        end
    end
`endif

endmodule

// File: tb/tb_lat_line_mem.sv
module tb_lat_line_mem;

  localparam int LAT = 4;

  logic clk;
  logic reset;

  // Main instance: defaults (2 ports, 4-word lines, latency 4)
  logic [1:0]   req_valid;
  logic [1:0]   req_write;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic [7:0]   req_wmask;
  logic [1:0]   ready;
  logic [1:0]   resp_valid;
  logic [127:0] resp_rdata;
  logic [15:0]  resp_addr;
`ifdef LAT_LINE_MEM_STATS_EN
  logic [31:0]  stat_reads;
  logic [31:0]  stat_writes;
`endif

  // Sweep instance: 3 ports, 1-word lines, latency 1
  logic [2:0]   s_req_valid;
  logic [2:0]   s_req_write;
  logic [23:0]  s_req_addr;
  logic [47:0]  s_req_wdata;
  logic [2:0]   s_req_wmask;
  logic [2:0]   s_ready;
  logic [2:0]   s_resp_valid;
  logic [47:0]  s_resp_rdata;
  logic [23:0]  s_resp_addr;
`ifdef LAT_LINE_MEM_STATS_EN
  logic [47:0]  s_stat_reads;
  logic [47:0]  s_stat_writes;
`endif

  int checks = 0;
  int errors = 0;

  lat_line_mem dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .ready(ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_addr(resp_addr)
`ifdef LAT_LINE_MEM_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
  );

  lat_line_mem #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LINE_WORDS(1), .LATENCY(1),
                 .NUM_PORTS(3)) dut_s (
    .clk(clk), .reset(reset),
    .req_valid(s_req_valid), .req_write(s_req_write), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .req_wmask(s_req_wmask),
    .ready(s_ready), .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
    .resp_addr(s_resp_addr)
`ifdef LAT_LINE_MEM_STATS_EN
    , .stat_reads(s_stat_reads), .stat_writes(s_stat_writes)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One op on the main instance; request held (and scrambled) while busy.
  task automatic run_op(input int p, input bit wr, input logic [7:0] a,
                        input logic [63:0] wd, input logic [3:0] wm,
                        output logic [63:0] rd, output logic [7:0] ra);
    int n;
    int lows;
    bit seen;
    @(negedge clk);
    check("ready_before", 64'(ready[p]), 64'd1);
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[p*8 +: 8]    = a;
    req_wdata[p*64 +: 64] = wd;
    req_wmask[p*4 +: 4]   = wm;
    @(posedge clk);
    #1;
    req_write[p] = ~wr;
    req_addr[p*8 +: 8]    = ~a;
    req_wdata[p*64 +: 64] = ~wd;
    req_wmask[p*4 +: 4]   = ~wm;
    n = 0; lows = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid[p]) seen = 1'b1;
      else if (!ready[p]) lows++;
    end
    req_valid[p] = 1'b0;
    check("resp_seen", 64'(seen), 64'd1);
    check("latency", 64'(n - 1), 64'(LAT));
    check("ready_low_cycles", 64'(lows), 64'(LAT));
    check("ready_at_resp", 64'(ready[p]), 64'd1);
    rd = resp_rdata[p*64 +: 64];
    ra = resp_addr[p*8 +: 8];
    @(negedge clk);
    check("resp_one_cycle", 64'(resp_valid[p]), 64'd0);
  endtask

  // Wait for port-0 completion after a dual accept, bounded.
  task automatic wait_dual(input string name);
    int n;
    n = 0;
    while (!resp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 64'(n - 1), 64'(LAT));
    check({name, "_both_valid"}, 64'(resp_valid), 64'd3);
  endtask

  typedef struct {
    int          port;
    bit          wr;
    logic [7:0]  addr;
    logic [63:0] wd;
    logic [3:0]  wm;
    bit          chk_rd;
    logic [63:0] exp_rd;
    logic [7:0]  exp_ad;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [63:0] rd;
    logic [7:0]  ra;
    int pulses;

    vecs[0]  = '{0, 1'b1, 8'h20, 64'h0004_0003_0002_0001, 4'hF, 1'b1, 64'h0, 8'h20};
    vecs[1]  = '{0, 1'b0, 8'h23, 64'h0,                   4'h0, 1'b1, 64'h0004_0003_0002_0001, 8'h20};
    vecs[2]  = '{0, 1'b1, 8'h22, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 1'b1, 64'h0004_0003_0002_0001, 8'h20};
    vecs[3]  = '{0, 1'b0, 8'h21, 64'h0,                   4'h0, 1'b1, 64'h0004_0003_0002_0001, 8'h20};
    vecs[4]  = '{1, 1'b1, 8'h40, 64'h0,                   4'hF, 1'b1, 64'h0, 8'h40};
    vecs[5]  = '{1, 1'b1, 8'h41, 64'h000D_000C_000B_000A, 4'b0101, 1'b1, 64'h0, 8'h40};
    vecs[6]  = '{1, 1'b0, 8'h40, 64'h0,                   4'h0, 1'b1, 64'h0000_000C_0000_000A, 8'h40};
    vecs[7]  = '{0, 1'b1, 8'hFD, 64'h9999_8888_7777_6666, 4'hF, 1'b1, 64'h0004_0003_0002_0001, 8'hFC};
    vecs[8]  = '{0, 1'b0, 8'hFF, 64'h0,                   4'h0, 1'b1, 64'h9999_8888_7777_6666, 8'hFC};
    vecs[9]  = '{1, 1'b0, 8'h42, 64'h0,                   4'h0, 1'b1, 64'h0000_000C_0000_000A, 8'h40};
    vecs[10] = '{1, 1'b1, 8'h83, 64'h0000_0000_0000_7777, 4'hF, 1'b1, 64'h0000_000C_0000_000A, 8'h80};

    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    s_req_valid = '0; s_req_write = '0; s_req_addr = '0; s_req_wdata = '0; s_req_wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd3);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata_hi", resp_rdata[127:64], 64'd0);
    check("rst_rdata_lo", resp_rdata[63:0], 64'd0);
    check("rst_addr", 64'(resp_addr), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd7);
    check("rst_s_resp_valid", 64'(s_resp_valid), 64'd0);
`ifdef LAT_LINE_MEM_STATS_EN
    check("rst_stat_reads", 64'(stat_reads), 64'd0);
    check("rst_stat_writes", 64'(stat_writes), 64'd0);
`endif
    reset = 1'b0;

    // ---------------- table-driven single-port ops ----------------
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].wm, rd, ra);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_addr", i), 64'(ra), 64'(vecs[i].exp_ad));
    end
`ifdef LAT_LINE_MEM_STATS_EN
    check("stat_reads_p0", 64'(stat_reads[15:0]), 64'd3);
    check("stat_writes_p0", 64'(stat_writes[15:0]), 64'd3);
    check("stat_reads_p1", 64'(stat_reads[31:16]), 64'd2);
    check("stat_writes_p1", 64'(stat_writes[31:16]), 64'd3);
`endif

    // ---------------- write collision on word 0x10 ----------------
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b11;
    req_addr  = {8'h10, 8'h10};
    req_wdata = {64'h0000_0000_0000_2222, 64'h0000_0000_0000_1111};
    req_wmask = {4'b0001, 4'b0001};
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_dual("collision");
    run_op(0, 1'b0, 8'h10, 64'h0, 4'h0, rd, ra);
    check("collision_word", 64'(rd[15:0]), 64'h1111);

    // ---------------- read/write overlap on word 0x10 ----------------
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b01;
    req_addr  = {8'h10, 8'h10};
    req_wdata = {64'h0, 64'h0000_0000_0000_BEEF};
    req_wmask = {4'b0000, 4'b0001};
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_dual("overlap");
    check("overlap_old_data", 64'(resp_rdata[79:64]), 64'h1111);
    run_op(1, 1'b0, 8'h10, 64'h0, 4'h0, rd, ra);
    check("overlap_new_data", 64'(rd[15:0]), 64'hBEEF);

    // ---------------- reset abort ----------------
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[7:0] = 8'h80; req_wdata[63:0] = 64'h0000_0000_0000_5555; req_wmask[3:0] = 4'b0001;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) pulses++;
      if (i == 2) reset = 1'b1;
      if (i == 3) begin
        reset = 1'b0;
        check("abort_ready", 64'(ready), 64'd3);
        check("abort_rdata_cleared", resp_rdata[63:0], 64'd0);
      end
    end
    check("abort_no_resp", 64'(pulses), 64'd0);
`ifdef LAT_LINE_MEM_STATS_EN
    check("abort_stats_cleared", 64'(stat_writes), 64'd0);
`endif
    run_op(0, 1'b0, 8'h80, 64'h0, 4'h0, rd, ra);
    check("abort_mem_kept", rd, 64'h0000_0000_0000_7777);

    // ---------------- sweep instance: latency 1, 1-word lines ----------------
    @(negedge clk);
    s_req_valid[2] = 1'b1; s_req_write[2] = 1'b1;
    s_req_addr[23:16] = 8'hFF; s_req_wdata[47:32] = 16'hABCD; s_req_wmask[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("s_busy_ready", 64'(s_ready[2]), 64'd0);
    check("s_busy_valid", 64'(s_resp_valid[2]), 64'd0);
    s_req_write[2] = 1'b0;
    @(negedge clk);
    check("s_wr_valid", 64'(s_resp_valid[2]), 64'd1);
    check("s_wr_ready", 64'(s_ready[2]), 64'd1);
    check("s_wr_addr", 64'(s_resp_addr[23:16]), 64'hFF);
    @(negedge clk);
    check("s_rd_busy_valid", 64'(s_resp_valid[2]), 64'd0);
    check("s_rd_busy_ready", 64'(s_ready[2]), 64'd0);
    s_req_valid[2] = 1'b0;
    @(negedge clk);
    check("s_rd_valid", 64'(s_resp_valid[2]), 64'd1);
    check("s_rd_data", 64'(s_resp_rdata[47:32]), 64'hABCD);
`ifdef LAT_LINE_MEM_STATS_EN
    check("s_stat_reads_p2", 64'(s_stat_reads[47:32]), 64'd1);
    check("s_stat_writes_p2", 64'(s_stat_writes[47:32]), 64'd1);
`endif

    // Continuous req_valid on port 0: one op per two edges.
    s_req_valid[0] = 1'b1; s_req_write[0] = 1'b0; s_req_addr[7:0] = 8'hFF;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_resp_valid[0]) pulses++;
    end
    s_req_valid[0] = 1'b0;
    check("s_throughput", 64'(pulses), 64'd4);
    check("s_p0_data", 64'(s_resp_rdata[15:0]), 64'hABCD);
    check("s_p0_addr", 64'(s_resp_addr[7:0]), 64'hFF);
`ifdef LAT_LINE_MEM_STATS_EN
    check("s_stat_reads_p0", 64'(s_stat_reads[15:0]), 64'd4);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
